// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with one LRU bit per set.
// Lookup on pcF is combinational; training from the memory stage lands on the clock edge.
module branch_target_buffer #(
  parameter int BTB_DEPTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        branchF,
  output logic [31:0] targetF,
  input  logic        flush_btb,
  input  logic [31:0] pcM,
  input  logic        branchM,
  input  logic        actual_takeM,
  input  logic [31:0] actual_targetM
);

  localparam int SETS  = 1 << BTB_DEPTH;
  localparam int TAG_W = 30 - BTB_DEPTH;

  logic [SETS-1:0]  valid0;
  logic [SETS-1:0]  valid1;
  logic [SETS-1:0]  lru;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic [31:0]      tgt0 [SETS];
  logic [31:0]      tgt1 [SETS];

  logic [BTB_DEPTH-1:0] f_idx;
  logic [TAG_W-1:0]     f_tag;
  logic                 f_hit0;
  logic                 f_hit1;
  logic [BTB_DEPTH-1:0] m_idx;
  logic [TAG_W-1:0]     m_tag;
  logic                 m_hit0;
  logic                 m_hit1;
  logic                 victim;
  logic                 alloc0;
  logic                 alloc1;
  logic                 wr_tgt0;
  logic                 wr_tgt1;
  logic                 lru_we;
  logic                 lru_new;
  logic                 unused_pc_low;

  // Word-aligned PCs: the byte-offset bits never select anything.
  assign unused_pc_low = ^{pcF[1:0], pcM[1:0]};

  assign f_idx  = pcF[BTB_DEPTH+1:2];
  assign f_tag  = pcF[31:BTB_DEPTH+2];
  assign f_hit0 = valid0[f_idx] && (tag0[f_idx] == f_tag);
  assign f_hit1 = valid1[f_idx] && (tag1[f_idx] == f_tag);
  assign branchF = f_hit0 || f_hit1;

  // Lookup mux; way 0 wins if both ways ever hit.
  always_comb begin
    if (f_hit0) begin
      targetF = tgt0[f_idx];
    end else if (f_hit1) begin
      targetF = tgt1[f_idx];
    end else begin
      targetF = pcF + 32'd4;
    end
  end

  assign m_idx  = pcM[BTB_DEPTH+1:2];
  assign m_tag  = pcM[31:BTB_DEPTH+2];
  assign m_hit0 = valid0[m_idx] && (tag0[m_idx] == m_tag);
  assign m_hit1 = valid1[m_idx] && (tag1[m_idx] == m_tag);

  // Victim selection: fill invalid ways first, otherwise follow the LRU bit.
  always_comb begin
    if (!valid0[m_idx]) begin
      victim = 1'b0;
    end else if (!valid1[m_idx]) begin
      victim = 1'b1;
    end else begin
      victim = lru[m_idx];
    end
  end

  // Training decode: hit refreshes LRU (target only if taken), taken miss allocates.
  always_comb begin
    alloc0  = 1'b0;
    alloc1  = 1'b0;
    wr_tgt0 = 1'b0;
    wr_tgt1 = 1'b0;
    lru_we  = 1'b0;
    lru_new = 1'b0;
    if (branchM) begin
      if (m_hit0) begin
        wr_tgt0 = actual_takeM;
        lru_we  = 1'b1;
        lru_new = 1'b1;
      end else if (m_hit1) begin
        wr_tgt1 = actual_takeM;
        lru_we  = 1'b1;
        lru_new = 1'b0;
      end else if (actual_takeM) begin
        alloc0  = ~victim;
        alloc1  = victim;
        wr_tgt0 = ~victim;
        wr_tgt1 = victim;
        lru_we  = 1'b1;
        lru_new = ~victim;
      end else begin
        lru_we = 1'b0;
      end
    end else begin
      lru_we = 1'b0;
    end
  end

  // Valid and LRU state; flush overrides any same-cycle training.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (flush_btb) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (alloc0) valid0[m_idx] <= 1'b1;
      if (alloc1) valid1[m_idx] <= 1'b1;
      if (lru_we) lru[m_idx] <= lru_new;
    end
  end

  // Tag and target payload carries no reset; it is meaningless while invalid.
  always_ff @(posedge clk) begin
    if (!flush_btb) begin
      if (alloc0)  tag0[m_idx] <= m_tag;
      if (alloc1)  tag1[m_idx] <= m_tag;
      if (wr_tgt0) tgt0[m_idx] <= actual_targetM;
      if (wr_tgt1) tgt1[m_idx] <= actual_targetM;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: expected {branchF,targetF} are queued
// when a lookup is driven and popped when the outputs are sampled.
module tb_branch_target_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        branchF;
  logic [31:0] targetF;
  logic        flush_btb;
  logic [31:0] pcM;
  logic        branchM;
  logic        actual_takeM;
  logic [31:0] actual_targetM;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [32:0] exp;
  } exp_t;
  exp_t sb [$];

  branch_target_buffer #(.BTB_DEPTH(6)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .branchF(branchF), .targetF(targetF),
    .flush_btb(flush_btb), .pcM(pcM), .branchM(branchM),
    .actual_takeM(actual_takeM), .actual_targetM(actual_targetM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got hit=%0b tgt=%h, expected hit=%0b tgt=%h",
               tag, obs[32], obs[31:0], exp[32], exp[31:0]);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    exp_t e;
    e.tag = tag;
    e.exp = hit ? {1'b1, tgt} : {1'b0, pc + 32'd4};
    sb.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty queue at sample time");
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, {branchF, targetF}, e.exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    @(negedge clk);
    pcF = pc;
    push_exp(tag, pc, hit, tgt);
    #2;
    pop_cmp();
  endtask

  task automatic train(input logic [31:0] pc, input logic take, input logic [31:0] tgt);
    @(negedge clk);
    pcM = pc;
    actual_takeM = take;
    actual_targetM = tgt;
    branchM = 1'b1;
    @(posedge clk);
    #1;
    branchM = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush_btb = 1'b0;
    pcF = 32'h0000_1000;
    pcM = 32'h0;
    branchM = 1'b0;
    actual_takeM = 1'b0;
    actual_targetM = 32'h0;

    // reset state
    #2;
    push_exp("in_reset", 32'h0000_1000, 1'b0, 32'h0);
    pop_cmp();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    look("cold", 32'h0000_1000, 1'b0, 32'h0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    train(32'h0000_1000, 1'b1, 32'h0000_2000);
    look("alloc_hit", 32'h0000_1000, 1'b1, 32'h0000_2000);
    train(32'h0000_1000, 1'b0, 32'h0000_5555);
    look("nt_keep", 32'h0000_1000, 1'b1, 32'h0000_2000);
    train(32'h0000_3000, 1'b0, 32'h0000_3333);
    look("nt_miss", 32'h0000_3000, 1'b0, 32'h0);

    // LRU: set 0 shared by 0x1000 / 0x2000 / 0x3000
    train(32'h0000_2000, 1'b1, 32'h0000_2222);
    look("way1_hit", 32'h0000_2000, 1'b1, 32'h0000_2222);
    look("way0_hit", 32'h0000_1000, 1'b1, 32'h0000_2000);
    train(32'h0000_1000, 1'b1, 32'h0000_2000);
    train(32'h0000_3000, 1'b1, 32'h0000_3333);
    look("lru_keep", 32'h0000_1000, 1'b1, 32'h0000_2000);
    look("lru_new", 32'h0000_3000, 1'b1, 32'h0000_3333);
    look("lru_evict", 32'h0000_2000, 1'b0, 32'h0);

    // same-cycle lookup and training: no bypass
    @(negedge clk);
    pcF = 32'h0000_4000;
    pcM = 32'h0000_4000;
    actual_takeM = 1'b1;
    actual_targetM = 32'h0000_4444;
    branchM = 1'b1;
    push_exp("same_cyc_pre", 32'h0000_4000, 1'b0, 32'h0);
    push_exp("same_cyc_post", 32'h0000_4000, 1'b1, 32'h0000_4444);
    #2;
    pop_cmp();
    @(posedge clk);
    #1;
    branchM = 1'b0;
    @(negedge clk);
    pop_cmp();
    look("evict_lru0", 32'h0000_1000, 1'b0, 32'h0);
    look("keep_way1", 32'h0000_3000, 1'b1, 32'h0000_3333);

    // flush beats a same-cycle update
    train(32'h0000_1004, 1'b1, 32'h0000_A004);
    train(32'h0000_1008, 1'b1, 32'h0000_A008);
    train(32'h0000_100C, 1'b1, 32'h0000_A00C);
    look("pre_flush", 32'h0000_1008, 1'b1, 32'h0000_A008);
    @(negedge clk);
    flush_btb = 1'b1;
    pcM = 32'h0000_1010;
    actual_takeM = 1'b1;
    actual_targetM = 32'h0000_A010;
    branchM = 1'b1;
    @(posedge clk);
    #1;
    flush_btb = 1'b0;
    branchM = 1'b0;
    look("flush_a", 32'h0000_1004, 1'b0, 32'h0);
    look("flush_b", 32'h0000_1008, 1'b0, 32'h0);
    look("flush_c", 32'h0000_100C, 1'b0, 32'h0);
    look("flush_upd", 32'h0000_1010, 1'b0, 32'h0);
    look("flush_d", 32'h0000_4000, 1'b0, 32'h0);

    // async reset between edges
    train(32'h0000_1004, 1'b1, 32'h0000_7777);
    look("repop", 32'h0000_1004, 1'b1, 32'h0000_7777);
    @(negedge clk);
    pcF = 32'h0000_1004;
    #1;
    rst = 1'b1;
    push_exp("async_rst", 32'h0000_1004, 1'b0, 32'h0);
    #1;
    pop_cmp();
    @(negedge clk);
    rst = 1'b0;
    look("post_rst", 32'h0000_1004, 1'b0, 32'h0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
